// File: rtl/control_fsm_pkg.sv
//==============================================================================
// Module   : control_fsm_pkg
// Desc     : Shared mini-RISC encodings: opcodes, func codes, ALU/branch ops,
//            FSM state codes, instruction classes and the control word.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package control_fsm_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b000001;
    localparam logic [5:0] c_OP_COMPI = 6'b000010;
    localparam logic [5:0] c_OP_LW    = 6'b000011;
    localparam logic [5:0] c_OP_SW    = 6'b000100;
    localparam logic [5:0] c_OP_B     = 6'b000101;
    localparam logic [5:0] c_OP_BL    = 6'b000110;
    localparam logic [5:0] c_OP_BZ    = 6'b000111;
    localparam logic [5:0] c_OP_BNZ   = 6'b001000;
    localparam logic [5:0] c_OP_BLTZ  = 6'b001001;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;

    localparam logic [5:0] c_FN_ADD   = 6'b000001;
    localparam logic [5:0] c_FN_COMP  = 6'b000010;
    localparam logic [5:0] c_FN_AND   = 6'b000011;
    localparam logic [5:0] c_FN_XOR   = 6'b000100;
    localparam logic [5:0] c_FN_SHLL  = 6'b000101;
    localparam logic [5:0] c_FN_SHRL  = 6'b000110;
    localparam logic [5:0] c_FN_SHRA  = 6'b000111;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_COMP = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_XOR  = 4'b0011;
    localparam logic [3:0] c_ALU_SHLL = 4'b0100;
    localparam logic [3:0] c_ALU_SHRL = 4'b0101;
    localparam logic [3:0] c_ALU_SHRA = 4'b0110;

    localparam logic [4:0] c_BR_NONE  = 5'd0;
    localparam logic [4:0] c_BR_B     = 5'd1;
    localparam logic [4:0] c_BR_BL    = 5'd2;
    localparam logic [4:0] c_BR_BZ    = 5'd3;
    localparam logic [4:0] c_BR_BNZ   = 5'd4;
    localparam logic [4:0] c_BR_BLTZ  = 5'd5;

    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXEC   = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        ST_FETCH  = c_ST_FETCH,
        ST_DECODE = c_ST_DECODE,
        ST_EXEC   = c_ST_EXEC,
        ST_MEM    = c_ST_MEM,
        ST_WB     = c_ST_WB,
        ST_HALT   = c_ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_RTYPE  = 3'd1,
        CL_IMM    = 3'd2,
        CL_LOAD   = 3'd3,
        CL_STORE  = 3'd4,
        CL_BRANCH = 3'd5,
        CL_HALT   = 3'd6
    } iclass_t;

    typedef struct packed {
        logic       ir_load;
        logic       pc_write;
        logic [1:0] reg_write;
        logic [1:0] reg_write_mux_ctrl;
        logic       alu_mux_ctrl;
        logic       imm_mux_ctrl;
        logic [3:0] alu_op;
        logic       dmem_enable;
        logic       dmem_write_enable;
        logic [4:0] br_op;
        logic       is_branch;
    } ctrl_t;

    localparam ctrl_t c_CTRL_IDLE  = '0;
    localparam ctrl_t c_CTRL_FETCH = '{ir_load: 1'b1, default: '0};

    // Returns {legal, alu_op} for an R-type function field.
    function automatic logic [4:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            c_FN_ADD:  return {1'b1, c_ALU_ADD};
            c_FN_COMP: return {1'b1, c_ALU_COMP};
            c_FN_AND:  return {1'b1, c_ALU_AND};
            c_FN_XOR:  return {1'b1, c_ALU_XOR};
            c_FN_SHLL: return {1'b1, c_ALU_SHLL};
            c_FN_SHRL: return {1'b1, c_ALU_SHRL};
            c_FN_SHRA: return {1'b1, c_ALU_SHRA};
            default:   return {1'b0, c_ALU_ADD};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
//==============================================================================
// Module   : control_decode
// Desc     : Combinational opcode/func decoder: instruction class, ALU op,
//            branch op, link flag and illegal-instruction flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_decode
    import control_fsm_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output iclass_t    iclass,
    output logic [3:0] alu_op,
    output logic [4:0] br_op,
    output logic       is_link,
    output logic       illegal
);

    logic [4:0] w_rtype;

    assign w_rtype = rtype_alu(func);

    always_comb begin
        iclass  = CL_NONE;
        alu_op  = c_ALU_ADD;
        br_op   = c_BR_NONE;
        is_link = 1'b0;
        illegal = 1'b0;
        case (opcode)
            c_OP_RTYPE: begin
                iclass  = CL_RTYPE;
                alu_op  = w_rtype[3:0];
                illegal = ~w_rtype[4];
            end
            c_OP_ADDI: begin
                iclass = CL_IMM;
                alu_op = c_ALU_ADD;
            end
            c_OP_COMPI: begin
                iclass = CL_IMM;
                alu_op = c_ALU_COMP;
            end
            c_OP_LW:   iclass = CL_LOAD;
            c_OP_SW:   iclass = CL_STORE;
            c_OP_B: begin
                iclass = CL_BRANCH;
                br_op  = c_BR_B;
            end
            c_OP_BL: begin
                iclass  = CL_BRANCH;
                br_op   = c_BR_BL;
                is_link = 1'b1;
            end
            c_OP_BZ: begin
                iclass = CL_BRANCH;
                br_op  = c_BR_BZ;
            end
            c_OP_BNZ: begin
                iclass = CL_BRANCH;
                br_op  = c_BR_BNZ;
            end
            c_OP_BLTZ: begin
                iclass = CL_BRANCH;
                br_op  = c_BR_BLTZ;
            end
            c_OP_HALT: iclass = CL_HALT;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
//==============================================================================
// Module   : control_fsm
// Desc     : Multi-cycle mini-RISC control unit (Moore FSM, registered outputs).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode_in,
    input  logic [5:0] func_in,
    output logic [1:0] reg_write,
    output logic       imm_mux_ctrl,
    output logic       alu_mux_ctrl,
    output logic [3:0] alu_op,
    output logic       dmem_enable,
    output logic       dmem_write_enable,
    output logic [1:0] reg_write_mux_ctrl,
    output logic [4:0] br_op,
    output logic       is_branch,
    output logic       ir_load,
    output logic       pc_write,
    output logic       halted,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_opcode;
    logic [5:0] r_func;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_next;
    logic       r_halted;
    logic       r_illegal;

    logic [5:0] w_dec_opcode;
    logic [5:0] w_dec_func;
    iclass_t    w_iclass;
    logic [3:0] w_alu_op;
    logic [4:0] w_br_op;
    logic       w_is_link;
    logic       w_dec_illegal;

    // In DECODE the live inputs are decoded so EXEC outputs can be registered
    // on the same edge that latches them; afterwards only the latched copy counts.
    assign w_dec_opcode = (r_state == ST_DECODE) ? opcode_in : r_opcode;
    assign w_dec_func   = (r_state == ST_DECODE) ? func_in   : r_func;

    control_decode u_decode (
        .opcode  (w_dec_opcode),
        .func    (w_dec_func),
        .iclass  (w_iclass),
        .alu_op  (w_alu_op),
        .br_op   (w_br_op),
        .is_link (w_is_link),
        .illegal (w_dec_illegal)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: begin
                if (w_dec_illegal || (w_iclass == CL_HALT))
                    w_state_next = ST_HALT;
                else
                    w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (w_iclass)
                    CL_BRANCH:         w_state_next = ST_FETCH;
                    CL_LOAD, CL_STORE: w_state_next = ST_MEM;
                    default:           w_state_next = ST_WB;
                endcase
            end
            ST_MEM:    w_state_next = (w_iclass == CL_LOAD) ? ST_WB : ST_FETCH;
            ST_WB:     w_state_next = ST_FETCH;
            ST_HALT:   w_state_next = ST_HALT;
            default:   w_state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl_next = c_CTRL_IDLE;
        if (w_state_next == ST_FETCH) begin
            w_ctrl_next.ir_load = 1'b1;
        end else if (w_state_next inside {ST_EXEC, ST_MEM, ST_WB}) begin
            // ALU controls stay stable from EXEC through the final state
            if (w_iclass != CL_BRANCH) begin
                w_ctrl_next.alu_op       = w_alu_op;
                w_ctrl_next.alu_mux_ctrl = (w_iclass != CL_RTYPE);
                w_ctrl_next.imm_mux_ctrl = (w_iclass == CL_LOAD) || (w_iclass == CL_STORE);
            end
            case (w_state_next)
                ST_EXEC: begin
                    if (w_iclass == CL_BRANCH) begin
                        w_ctrl_next.br_op     = w_br_op;
                        w_ctrl_next.is_branch = 1'b1;
                        w_ctrl_next.pc_write  = 1'b1;
                        if (w_is_link) begin
                            w_ctrl_next.reg_write          = 2'b10;
                            w_ctrl_next.reg_write_mux_ctrl = 2'b01;
                        end
                    end
                end
                ST_MEM: begin
                    w_ctrl_next.dmem_enable = 1'b1;
                    if (w_iclass == CL_STORE) begin
                        w_ctrl_next.dmem_write_enable = 1'b1;
                        w_ctrl_next.pc_write          = 1'b1;
                    end
                end
                ST_WB: begin
                    w_ctrl_next.reg_write          = 2'b01;
                    w_ctrl_next.reg_write_mux_ctrl = (w_iclass == CL_LOAD) ? 2'b00 : 2'b10;
                    w_ctrl_next.pc_write           = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_opcode  <= '0;
            r_func    <= '0;
            r_ctrl    <= c_CTRL_FETCH;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ctrl   <= w_ctrl_next;
            r_halted <= (w_state_next == ST_HALT);
            if (r_state == ST_DECODE) begin
                r_opcode <= opcode_in;
                r_func   <= func_in;
                if (w_dec_illegal)
                    r_illegal <= 1'b1;
            end
        end
    end

    assign ir_load            = r_ctrl.ir_load;
    assign pc_write           = r_ctrl.pc_write;
    assign reg_write          = r_ctrl.reg_write;
    assign reg_write_mux_ctrl = r_ctrl.reg_write_mux_ctrl;
    assign alu_mux_ctrl       = r_ctrl.alu_mux_ctrl;
    assign imm_mux_ctrl       = r_ctrl.imm_mux_ctrl;
    assign alu_op             = r_ctrl.alu_op;
    assign dmem_enable        = r_ctrl.dmem_enable;
    assign dmem_write_enable  = r_ctrl.dmem_write_enable;
    assign br_op              = r_ctrl.br_op;
    assign is_branch          = r_ctrl.is_branch;
    assign halted             = r_halted;
    assign illegal            = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
//==============================================================================
// Module   : tb_control_fsm
// Desc     : Scoreboard bench for control_fsm with directed per-cycle vectors.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode_in = '0;
    logic [5:0] func_in = '0;
    logic [1:0] reg_write;
    logic       imm_mux_ctrl;
    logic       alu_mux_ctrl;
    logic [3:0] alu_op;
    logic       dmem_enable;
    logic       dmem_write_enable;
    logic [1:0] reg_write_mux_ctrl;
    logic [4:0] br_op;
    logic       is_branch;
    logic       ir_load;
    logic       pc_write;
    logic       halted;
    logic       illegal;

    control_fsm dut (
        .clk                (clk),
        .rst                (rst),
        .opcode_in          (opcode_in),
        .func_in            (func_in),
        .reg_write          (reg_write),
        .imm_mux_ctrl       (imm_mux_ctrl),
        .alu_mux_ctrl       (alu_mux_ctrl),
        .alu_op             (alu_op),
        .dmem_enable        (dmem_enable),
        .dmem_write_enable  (dmem_write_enable),
        .reg_write_mux_ctrl (reg_write_mux_ctrl),
        .br_op              (br_op),
        .is_branch          (is_branch),
        .ir_load            (ir_load),
        .pc_write           (pc_write),
        .halted             (halted),
        .illegal            (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [21:0] obs;

    assign obs = {ir_load, pc_write, reg_write, reg_write_mux_ctrl, alu_mux_ctrl,
                  imm_mux_ctrl, alu_op, dmem_enable, dmem_write_enable, br_op,
                  is_branch, halted, illegal};

    // Field order: ir pc rw rwm am im aop de dwe bop isb halted illegal
    function automatic logic [21:0] mkv(input int ir, input int pc, input int rw,
                                        input int rwm, input int am, input int im,
                                        input int aop, input int de, input int dwe,
                                        input int bop, input int isb, input int h,
                                        input int il);
        return {1'(ir), 1'(pc), 2'(rw), 2'(rwm), 1'(am), 1'(im), 4'(aop),
                1'(de), 1'(dwe), 5'(bop), 1'(isb), 1'(h), 1'(il)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string n, input logic [21:0] v);
        exp_t e;
        tick();
        e.name = n;
        e.v    = v;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            total++;
            if (obs !== mon_e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b", mon_e.name, obs, mon_e.v);
            end
        end
        if (!rst) begin
            total++;
            if ((dmem_write_enable && !dmem_enable) || ((reg_write != 2'b00) && dmem_write_enable)) begin
                bad++;
                $display("FAIL mem_invariant: got de=%b dwe=%b rw=%b want no illegal combination",
                         dmem_enable, dmem_write_enable, reg_write);
            end
        end
    end

    logic [21:0] v_f;
    logic [21:0] v_z;

    initial begin
        v_f = mkv(1,0,0,0,0,0,0,0,0,0,0,0,0);
        v_z = '0;

        rst = 1'b1;
        tick();
        step("reset_state", v_f);
        rst = 1'b0;

        // R-type xor; opcode scrambled after DECODE must not matter
        opcode_in = 6'b000000; func_in = 6'b000100;
        step("xor_decode", v_z);
        step("xor_exec",   mkv(0,0,0,0,0,0,3,0,0,0,0,0,0));
        opcode_in = 6'h3e; func_in = 6'h3f;
        step("xor_wb",     mkv(0,1,1,2,0,0,3,0,0,0,0,0,0));
        step("xor_fetch",  v_f);

        opcode_in = 6'b000001; func_in = 6'h15;
        step("addi_decode", v_z);
        step("addi_exec",   mkv(0,0,0,0,1,0,0,0,0,0,0,0,0));
        step("addi_wb",     mkv(0,1,1,2,1,0,0,0,0,0,0,0,0));
        step("addi_fetch",  v_f);

        opcode_in = 6'b000011;
        step("lw_decode", v_z);
        step("lw_exec",   mkv(0,0,0,0,1,1,0,0,0,0,0,0,0));
        step("lw_mem",    mkv(0,0,0,0,1,1,0,1,0,0,0,0,0));
        step("lw_wb",     mkv(0,1,1,0,1,1,0,0,0,0,0,0,0));
        step("lw_fetch",  v_f);

        opcode_in = 6'b000100;
        step("sw_decode", v_z);
        step("sw_exec",   mkv(0,0,0,0,1,1,0,0,0,0,0,0,0));
        step("sw_mem",    mkv(0,1,0,0,1,1,0,1,1,0,0,0,0));
        step("sw_fetch",  v_f);

        opcode_in = 6'b000101;
        step("b_decode", v_z);
        step("b_exec",   mkv(0,1,0,0,0,0,0,0,0,1,1,0,0));
        step("b_fetch",  v_f);

        opcode_in = 6'b000110;
        step("bl_decode", v_z);
        step("bl_exec",   mkv(0,1,2,1,0,0,0,0,0,2,1,0,0));
        step("bl_fetch",  v_f);

        opcode_in = 6'b001000;
        step("bnz_decode", v_z);
        step("bnz_exec",   mkv(0,1,0,0,0,0,0,0,0,4,1,0,0));
        step("bnz_fetch",  v_f);

        opcode_in = 6'b000010;
        step("compi_decode", v_z);
        step("compi_exec",   mkv(0,0,0,0,1,0,1,0,0,0,0,0,0));
        step("compi_wb",     mkv(0,1,1,2,1,0,1,0,0,0,0,0,0));
        step("compi_fetch",  v_f);

        opcode_in = 6'b000000; func_in = 6'b000111;
        step("shra_decode", v_z);
        step("shra_exec",   mkv(0,0,0,0,0,0,6,0,0,0,0,0,0));
        step("shra_wb",     mkv(0,1,1,2,0,0,6,0,0,0,0,0,0));
        step("shra_fetch",  v_f);

        // lw aborted by reset in MEM
        opcode_in = 6'b000011;
        step("abort_decode", v_z);
        step("abort_exec",   mkv(0,0,0,0,1,1,0,0,0,0,0,0,0));
        step("abort_mem",    mkv(0,0,0,0,1,1,0,1,0,0,0,0,0));
        rst = 1'b1;
        step("abort_fetch",  v_f);
        rst = 1'b0;

        opcode_in = 6'b111110;
        step("illop_decode", v_z);
        for (int i = 0; i < 10; i++)
            step($sformatf("illop_halt_%0d", i), mkv(0,0,0,0,0,0,0,0,0,0,0,1,1));
        rst = 1'b1;
        step("illop_reset", v_f);
        rst = 1'b0;

        opcode_in = 6'b000000; func_in = 6'b000000;
        step("badfn_decode", v_z);
        step("badfn_halt_0", mkv(0,0,0,0,0,0,0,0,0,0,0,1,1));
        step("badfn_halt_1", mkv(0,0,0,0,0,0,0,0,0,0,0,1,1));
        rst = 1'b1;
        step("badfn_reset", v_f);
        rst = 1'b0;

        opcode_in = 6'b111111;
        step("halt_decode", v_z);
        for (int i = 0; i < 3; i++)
            step($sformatf("halt_park_%0d", i), mkv(0,0,0,0,0,0,0,0,0,0,0,1,0));
        rst = 1'b1;
        step("halt_reset", v_f);
        rst = 1'b0;
        opcode_in = 6'b000000; func_in = 6'b000001;
        step("post_reset_decode", v_z);

        repeat (3) tick();
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
